mem_responder: RTL and testbench

Byte-wide memory responder on the far end of the CPU memory bus driven by the memory controller. It owns the 128 KiB main RAM and a small I/O window with a character-output FIFO and a halt register. It answers `mem_a`/`mem_wr`/`mem_din` and returns read data on `mem_dout` one cycle later, matching the controller's pipelined byte sequencing. It stands in for the board RAM plus host-interface byte sink in simulation, and front-ends the BRAM on FPGA.

---
 rtl/mem_responder_pkg.sv | 32 +++
 rtl/mem_responder_byte_fifo.sv | 97 +++++++++
 rtl/mem_responder.sv | 112 +++++++++++
 tb/tb_mem_responder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: I/O window location, I/O register
// offsets and the access-kind decode used by the top level.
package mem_responder_pkg;

   // I/O window occupies the top quarter of the 18-bit decoded space.
   localparam logic [17:0] IO_BASE = 18'h30000;
   localparam logic [2:0]  IO_OUT  = 3'd0;  // character output FIFO
   localparam logic [2:0]  IO_HALT = 3'd4;  // halt register (write) / FIFO count (read)

   typedef enum logic [1:0] {
      AccRam,
      AccIoOut,
      AccIoCtl,
      AccIoNone
   } acc_e;

   // region is mem_a[17:16], off is mem_a[2:0].
   function automatic acc_e decode_acc(input logic [1:0] region, input logic [2:0] off);
      acc_e acc;
      if (region != IO_BASE[17:16]) begin
         acc = AccRam;
      end else if (off == IO_OUT) begin
         acc = AccIoOut;
      end else if (off == IO_HALT) begin
         acc = AccIoCtl;
      end else begin
         acc = AccIoNone;
      end
      return acc;
   endfunction

endpackage

// File: rtl/mem_responder_byte_fifo.sv
// Byte FIFO feeding the character-output sink.
//   clk, rst        : clock, asynchronous active-low reset
//   push, din       : enqueue request and data (caller gates with rdy)
//   pop             : dequeue request (caller gates with rdy)
//   head, valid     : registered head byte and non-empty flag
//   count           : current occupancy (one bit wider than the pointers)
//   full            : occupancy equals DEPTH
//   almost_full     : registered, free entries <= MARGIN after this cycle's update
module mem_responder_byte_fifo #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned MARGIN = 2,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [7:0]       din,
   input  logic             pop,
   output logic [7:0]       head,
   output logic             valid,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             almost_full
);

   logic [7:0]       mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [7:0]       head_q, head_d;
   logic             valid_q;
   logic             afull_q, afull_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign pop_ok  = pop && (count_q != '0);
   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign push_ok = push && (!full || pop_ok);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - CNT_W'(1);
      end
      // Next head: the byte being written now if it lands in the head slot,
      // otherwise the stored entry. Empty FIFO keeps the last head byte.
      if (count_d == '0) begin
         head_d = head_q;
      end else if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
         head_d = din;
      end else begin
         head_d = mem_q[rd_ptr_d];
      end
      afull_d = ((CNT_W'(DEPTH) - count_d) <= CNT_W'(MARGIN));
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
         afull_q  <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         valid_q  <= (count_d != '0);
         afull_q  <= afull_d;
      end
   end

   assign head        = head_q;
   assign valid       = valid_q;
   assign count       = count_q;
   assign almost_full = afull_q;

endmodule

// File: rtl/mem_responder.sv
// Byte-wide memory responder: 128 KiB RAM plus an I/O window holding a
// character-output FIFO and a halt register. Read data returns one cycle late.
//   clk, rst             : clock, asynchronous active-low reset
//   rdy                  : global ready, low freezes all state
//   mem_a, mem_wr, mem_din : byte address, write strobe, write data
//   mem_dout             : read data for the previous cycle's address
//   io_full              : output FIFO near full
//   tx_valid, tx_data, tx_ready : output byte stream handshake
//   sim_halt, overflow   : sticky status flags
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned ADDR_W      = 17,
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned FULL_MARGIN = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic        io_full,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        sim_halt,
   output logic        overflow
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]        ram [2**ADDR_W];
   logic [ADDR_W-1:0] ram_addr;
   acc_e              acc;
   logic              ram_we, push, pop, halt_set, drop;
   logic              fifo_full;
   logic [CNT_W-1:0]  fifo_count;
   logic [7:0]        rd_data;
   logic [7:0]        mem_dout_q;
   logic              halt_q, ovf_q;
   logic              unused_addr;

   // Address bits above the decoded range are ignored.
   assign unused_addr = ^mem_a[31:18];

   assign ram_addr = mem_a[ADDR_W-1:0];
   assign acc      = decode_acc(mem_a[17:16], mem_a[2:0]);
   assign ram_we   = rdy && mem_wr && (acc == AccRam);
   assign push     = rdy && mem_wr && (acc == AccIoOut);
   assign halt_set = rdy && mem_wr && (acc == AccIoCtl);
   assign pop      = rdy && tx_valid && tx_ready;
   assign drop     = push && fifo_full && !pop;

   always_comb begin
      rd_data = 8'h00;
      unique case (acc)
         AccRam:    rd_data = ram[ram_addr];
         AccIoCtl:  rd_data = 8'(fifo_count);
         AccIoOut:  rd_data = 8'h00;
         AccIoNone: rd_data = 8'h00;
      endcase
   end

   // RAM is deliberately left out of reset so preloaded contents survive.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[ram_addr] <= mem_din;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_dout_q <= 8'h00;
         halt_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else if (rdy) begin
         // Write cycles leave the read register untouched.
         if (!mem_wr) begin
            mem_dout_q <= rd_data;
         end
         if (halt_set) begin
            halt_q <= 1'b1;
         end
         if (drop) begin
            ovf_q <= 1'b1;
         end
      end
   end

   mem_responder_byte_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .MARGIN (FULL_MARGIN)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .din         (mem_din),
      .pop         (pop),
      .head        (tx_data),
      .valid       (tx_valid),
      .count       (fifo_count),
      .full        (fifo_full),
      .almost_full (io_full)
   );

   assign mem_dout = mem_dout_q;
   assign sim_halt = halt_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

   localparam int DEPTH  = 16;
   localparam int MARGIN = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic [31:0] mem_a = 32'h0;
   logic        mem_wr = 1'b0;
   logic [7:0]  mem_din = 8'h00;
   logic        tx_ready = 1'b0;
   logic [7:0]  mem_dout;
   logic        io_full;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        sim_halt;
   logic        overflow;
   logic [19:0] got_vec;

   int n_vec  = 0;
   int n_fail = 0;

   // Reference model state
   logic [7:0] ram_m [int];
   logic [7:0] exp_q [$];
   logic [7:0] exp_dout = 8'h00;
   logic [7:0] exp_txd  = 8'h00;
   logic       exp_halt = 1'b0;
   logic       exp_ovf  = 1'b0;

   always #5 clk = ~clk;

   mem_responder dut (
      .clk      (clk),
      .rst      (rst),
      .rdy      (rdy),
      .mem_a    (mem_a),
      .mem_wr   (mem_wr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout),
      .io_full  (io_full),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .sim_halt (sim_halt),
      .overflow (overflow)
   );

   assign got_vec = {mem_dout, tx_valid, tx_data, io_full, sim_halt, overflow};

   function automatic logic [19:0] exp_vec();
      return {exp_dout, exp_q.size() != 0, exp_txd, (DEPTH - exp_q.size()) <= MARGIN,
              exp_halt, exp_ovf};
   endfunction

   task automatic model_reset();
      exp_q.delete();
      exp_dout = 8'h00;
      exp_txd  = 8'h00;
      exp_halt = 1'b0;
      exp_ovf  = 1'b0;
   endtask

   // One bus cycle of the behavioural model, evaluated on pre-edge state.
   task automatic model_step(input logic [31:0] a, input logic wr, input logic [7:0] d,
                             input logic r, input logic txr);
      bit       io;
      bit [2:0] off;
      int       pre;
      bit       do_pop;
      if (!r) return;
      io     = (a[17:16] == 2'b11);
      off    = a[2:0];
      pre    = exp_q.size();
      do_pop = txr && (pre > 0);
      if (do_pop) void'(exp_q.pop_front());
      if (!io) begin
         if (wr) ram_m[int'(a[16:0])] = d;
         else    exp_dout = ram_m[int'(a[16:0])];
      end else if (wr) begin
         if (off == 3'd0) begin
            if (pre < DEPTH || do_pop) exp_q.push_back(d);
            else exp_ovf = 1'b1;
         end else if (off == 3'd4) begin
            exp_halt = 1'b1;
         end
      end else begin
         exp_dout = (off == 3'd4) ? 8'(pre) : 8'h00;
      end
      if (exp_q.size() > 0) exp_txd = exp_q[0];
   endtask

   task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d,
                        input logic r, input logic txr);
      mem_a    = a;
      mem_wr   = wr;
      mem_din  = d;
      rdy      = r;
      tx_ready = txr;
      model_step(a, wr, d, r, txr);
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      mem_wr   = 1'b0;
      tx_ready = 1'b0;
      #2 rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      model_reset();
      #1;
      n_vec++;
      if (got_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_state: got %h want %h", got_vec, exp_vec());
      end
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_raw();
      drive(32'h10, 1'b1, 8'hA5, 1'b1, 1'b0);
      drive(32'h10, 1'b0, 8'h00, 1'b1, 1'b0);
      n_vec++;
      if (mem_dout !== exp_dout) begin
         n_fail++;
         $display("FAIL raw_read: got %h want %h", mem_dout, exp_dout);
      end
   endtask

   task automatic test_burst();
      logic [7:0] pat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) drive(32'h100 + i, 1'b1, pat[i], 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         drive(32'h100 + i, 1'b0, 8'h00, 1'b1, 1'b0);
         n_vec++;
         if (mem_dout !== exp_dout) begin
            n_fail++;
            $display("FAIL burst_byte%0d: got %h want %h", i, mem_dout, exp_dout);
         end
      end
   endtask

   task automatic test_fifo_fill();
      logic ef;
      for (int i = 0; i < 17; i++) begin
         drive(32'h30000, 1'b1, 8'($urandom), 1'b1, 1'b0);
         ef = (DEPTH - exp_q.size()) <= MARGIN;
         n_vec++;
         if (io_full !== ef) begin
            n_fail++;
            $display("FAIL fill_io_full%0d: got %b want %b", i, io_full, ef);
         end
      end
      drive(32'h30004, 1'b0, 8'h00, 1'b1, 1'b0);
      n_vec++;
      if ({mem_dout, overflow} !== {exp_dout, exp_ovf}) begin
         n_fail++;
         $display("FAIL fill_count_ovf: got %h/%b want %h/%b", mem_dout, overflow,
                  exp_dout, exp_ovf);
      end
      for (int i = 0; i < 18; i++) begin
         drive(32'h10, 1'b0, 8'h00, 1'b1, 1'b1);
         n_vec++;
         if (got_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL fill_drain%0d: got %h want %h", i, got_vec, exp_vec());
         end
      end
   endtask

   task automatic test_full_passthrough();
      apply_reset();
      for (int i = 0; i < DEPTH; i++) drive(32'h30000, 1'b1, 8'($urandom), 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         drive(32'h30000, 1'b1, 8'($urandom), 1'b1, 1'b1);
         n_vec++;
         if (got_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL full_push_pop%0d: got %h want %h", i, got_vec, exp_vec());
         end
      end
      drive(32'h30004, 1'b0, 8'h00, 1'b1, 1'b0);
      n_vec++;
      if (got_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL full_count: got %h want %h", got_vec, exp_vec());
      end
      for (int i = 0; i < 17; i++) begin
         drive(32'h10, 1'b0, 8'h00, 1'b1, 1'b1);
         n_vec++;
         if (got_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL full_drain%0d: got %h want %h", i, got_vec, exp_vec());
         end
      end
   endtask

   task automatic test_halt_rdy();
      drive(32'h30004, 1'b1, 8'h00, 1'b1, 1'b0);
      n_vec++;
      if (sim_halt !== exp_halt) begin
         n_fail++;
         $display("FAIL halt_set: got %b want %b", sim_halt, exp_halt);
      end
      drive(32'h30000, 1'b1, 8'h3C, 1'b1, 1'b0);
      drive(32'h100, 1'b0, 8'h00, 1'b1, 1'b0);
      // rdy low: RAM write, read and handshake must all be ignored
      drive(32'h10, 1'b1, 8'h5A, 1'b0, 1'b1);
      n_vec++;
      if (got_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL rdy_low_write: got %h want %h", got_vec, exp_vec());
      end
      drive(32'h101, 1'b0, 8'h00, 1'b0, 1'b1);
      n_vec++;
      if (got_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL rdy_low_read: got %h want %h", got_vec, exp_vec());
      end
      drive(32'h10, 1'b0, 8'h00, 1'b1, 1'b0);
      n_vec++;
      if (mem_dout !== exp_dout) begin
         n_fail++;
         $display("FAIL rdy_low_ram_kept: got %h want %h", mem_dout, exp_dout);
      end
   endtask

   task automatic test_reset_midburst();
      for (int i = 0; i < 5; i++) drive(32'h30000, 1'b1, 8'($urandom), 1'b1, 1'b0);
      drive(32'h100, 1'b0, 8'h00, 1'b1, 1'b0);
      drive(32'h101, 1'b0, 8'h00, 1'b1, 1'b0);
      mem_a = 32'h102;
      #2 rst = 1'b0;
      model_reset();
      #1;
      n_vec++;
      if (got_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL midburst_reset: got %h want %h", got_vec, exp_vec());
      end
      @(posedge clk);
      #1 rst = 1'b1;
      drive(32'h103, 1'b0, 8'h00, 1'b1, 1'b0);
      n_vec++;
      if (mem_dout !== exp_dout) begin
         n_fail++;
         $display("FAIL midburst_ram_kept: got %h want %h", mem_dout, exp_dout);
      end
      drive(32'h30004, 1'b0, 8'h00, 1'b1, 1'b0);
      n_vec++;
      if (got_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL midburst_empty: got %h want %h", got_vec, exp_vec());
      end
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [31:0] hi;
      int          sel;
      for (int i = 0; i < 16; i++) drive(32'h200 + i, 1'b1, 8'($urandom), 1'b1, 1'b0);
      for (int i = 0; i < 400; i++) begin
         sel = $urandom_range(0, 9);
         hi  = $urandom & 32'hFFFC_0000;
         if (sel < 4) begin
            a = hi | 32'h200 | 32'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) a = a | 32'h2_0000;  // alias with bit 17 set
         end else if (sel < 8) begin
            a = hi | 32'h3_0000 | ($urandom & 32'hFFF8);
         end else if (sel == 8) begin
            a = hi | 32'h3_0004 | ($urandom & 32'hFFF8);
         end else begin
            a = hi | 32'h3_0000 | ($urandom & 32'hFFF8) | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) a = a | 32'h4;
         end
         drive(a, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 4) != 0,
               $urandom_range(0, 2) == 0);
         n_vec++;
         if (got_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL random%0d a=%h: got %h want %h", i, a, got_vec, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_raw();
      test_burst();
      test_fifo_fill();
      test_full_passthrough();
      test_halt_rdy();
      test_reset_midburst();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
